psram_cmd_responder: RTL and testbench
======================================

# psram_cmd_responder

Synthesizable PSRAM-side command responder: the device end of the serial link that the PSRAM initialization controller drives. It samples `mem_ce`/`mem_sio` and decodes SPI commands (1 bit per clock on SIO[0]) and QPI commands (4 bits per clock on SIO[3:0]). It tracks the reset-enable/reset sequence and the SPI↔QPI mode, and answers Read-ID in SPI mode. It serves both as the bench responder for the controller and as an on-FPGA loopback target.

## Interface
- `MF_ID`, 8'h0D, first Read-ID byte.
- `KGD`, 8'h5D, second Read-ID byte.
- `mem_clk` in 1, sole clock; every input is sampled and every output is updated on its rising edge.
- `rst` in 1, synchronous, active-high reset.
- `mem_ce` in 1, chip enable, active low.
- `sio_in` in 4, SIO pin inputs.
- `sio_out` out 4, SIO drive values.
- `sio_oe` out 4, per-pin output enable; only bit 1 is ever set.
- `cmd_valid` out 1, one-cycle pulse when a full 8-bit command is received.
- `cmd_byte` out 8, last completed command; holds its value between commands.
- `qpi_mode` out 1, 0 = SPI, 1 = QPI.
- `rst_done` out 1, one-cycle pulse when a software reset (RST) executes.
- `rsten_armed` out 1, high after a completed RSTEN command until the next completed command.

## Operation
- States:
  - IDLE: CE high.
  - CMD: shifting in the command.
  - ADDR: 24 don't-care address bits, SPI 0x9F only.
  - DOUT: driving ID bits.
  - IGNORE: discard everything until CE goes high.
- IDLE→CMD: on an edge where `mem_ce`=0. That same edge samples the first command bit or nibble.
- SPI command capture: MSB first from `sio_in[0]`, 8 edges.
- QPI command capture: high nibble first from `sio_in[3:0]`, 2 edges.
- Command completion, on the edge that samples the last bit:
  - `cmd_byte` loads the command.
  - `cmd_valid` is high for the following cycle.
- Decode on completion:
  - 0x66 RSTEN: set `rsten_armed`.
  - 0x99 RST: only if `rsten_armed`=1. Effect: `qpi_mode`←0, `rst_done` pulse, arm cleared.
  - 0x35: `qpi_mode`←1.
  - 0xF5: `qpi_mode`←0, accepted in QPI mode only.
  - 0x9F in SPI mode: go to ADDR. In QPI mode it is treated as unknown.
  - Any other value: no effect.
- Every completed command other than 0x66 clears `rsten_armed`, including an unarmed 0x99.
- After completion, any command other than SPI 0x9F goes to IGNORE.
- ADDR: counts 24 edges. On the 24th edge, set `sio_oe[1]`=1 and `sio_out[1]`=MF_ID[7], then go to DOUT.
- DOUT:
  - Each edge shifts the next bit onto `sio_out[1]`, in the order MF_ID[6:0], then KGD[7:0], then 0 until CE goes high.
  - Each bit holds for exactly one cycle.
- Any state, `mem_ce` sampled high: go to IDLE, `sio_oe`←0, bit counters cleared.
- A command aborted mid-shift (CE high before the last bit) produces no `cmd_valid` and causes no state change.

## Timing
- Reset values:
  - `sio_out`=0, `sio_oe`=0, `cmd_valid`=0, `rst_done`=0.
  - `cmd_byte`=0, `qpi_mode`=0, `rsten_armed`=0.
  - FSM goes to IGNORE if `mem_ce`=0 during reset, otherwise IDLE.
- Reset mid-command or mid-DOUT: the partial command is discarded; no new command starts until CE has been high for at least one edge.
- Command latency:
  - SPI: `cmd_valid` rises 8 edges after the first low-CE edge.
  - QPI: `cmd_valid` rises 2 edges after the first low-CE edge.
- Mode timing: `qpi_mode` and `rst_done` change on the same edge that `cmd_valid` rises. A command that starts on the next CE-low frame is decoded in the new mode.
- Read-ID: the initiator samples ID bit k on edge 33+k, counted from the first command edge.
- Bits sampled on edges where CE=1 are never counted.
- Extra bits after a completed command, within the same CE-low frame, are ignored.
- Back-to-back frames: one CE-high edge between frames is sufficient.

## Test plan
- SPI frames 0x66, 0x99, 0x35, each separated by CE high:
  - `cmd_valid` pulses 3 times, with `cmd_byte` = 66, 99, 35.
  - `rst_done` pulses once, on the 0x99 frame.
  - `qpi_mode`=1 after the third frame.
- SPI 0x99 without a preceding RSTEN: `cmd_valid`=1 and `cmd_byte`=0x99, but no `rst_done`. `qpi_mode` is unchanged.
- Arm then clear: frame 0x66, then frame 0x35, then frame 0x99. No `rst_done`; `qpi_mode` stays 1.
- Abort: CE low for 5 bits of 0x66, then CE high. No `cmd_valid`; `rsten_armed`=0; the next full frame decodes correctly.
- QPI mode, nibbles F then 5: `qpi_mode`→0 on completion. A subsequent SPI 0x35 sets it back to 1.
- SPI 0x9F plus 24 address bits, then 20 more clocks:
  - `sio_oe[1]`=1 from edge 32.
  - `sio_out[1]` carries 0x0D then 0x5D, MSB first, then zeros.
  - `sio_oe` drops to 0 one edge after CE goes high.
- `rst` asserted on the 4th bit of 0x66 with CE still low: all outputs reset; frame ignored. After CE high, the next frame 0x66 sets `rsten_armed`.

Source files
------------

// File: rtl/psram_cmd_responder.sv
`default_nettype none
// ============================================================================
// Module   : psram_cmd_responder
// Purpose  : PSRAM-side SPI/QPI command decoder with RSTEN/RST tracking,
//            QPI mode switching and SPI Read-ID response on SIO[1].
// Revision : 1.0 - initial release
// ============================================================================
module psram_cmd_responder #(
  parameter logic [7:0] MF_ID = 8'h0D,
  parameter logic [7:0] KGD   = 8'h5D
) (
  input  logic       mem_clk,
  input  logic       rst,
  input  logic       mem_ce,
  input  logic [3:0] sio_in,
  output logic [3:0] sio_out,
  output logic [3:0] sio_oe,
  output logic       cmd_valid,
  output logic [7:0] cmd_byte,
  output logic       qpi_mode,
  output logic       rst_done,
  output logic       rsten_armed
);

  localparam logic [7:0] c_cmd_rsten    = 8'h66;
  localparam logic [7:0] c_cmd_rst      = 8'h99;
  localparam logic [7:0] c_cmd_qpi_en   = 8'h35;
  localparam logic [7:0] c_cmd_qpi_exit = 8'hF5;
  localparam logic [7:0] c_cmd_rdid     = 8'h9F;
  localparam logic [4:0] c_addr_last    = 5'd23;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_ADDR   = 3'd2,
    S_DOUT   = 3'd3,
    S_IGNORE = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [4:0]  r_cnt;
  logic [6:0]  r_shift;
  logic [14:0] r_id;
  logic        r_dout;
  logic        r_oe;
  logic        r_valid;
  logic [7:0]  r_cmd;
  logic        r_qpi;
  logic        r_rst_done;
  logic        r_armed;
  logic        w_last;
  logic [7:0]  w_cmd_word;

  assign sio_out     = {2'b00, r_dout, 1'b0};
  assign sio_oe      = {2'b00, r_oe, 1'b0};
  assign cmd_valid   = r_valid;
  assign cmd_byte    = r_cmd;
  assign qpi_mode    = r_qpi;
  assign rst_done    = r_rst_done;
  assign rsten_armed = r_armed;

  always_comb begin
    w_state_next = r_state;
    w_cmd_word   = r_qpi ? {r_shift[3:0], sio_in} : {r_shift[6:0], sio_in[0]};
    w_last       = (r_state == S_CMD) && (r_qpi ? (r_cnt == 5'd1) : (r_cnt == 5'd7));
    if (mem_ce) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: w_state_next = S_CMD;
        S_CMD: begin
          if (w_last) begin
            w_state_next = (!r_qpi && (w_cmd_word == c_cmd_rdid)) ? S_ADDR : S_IGNORE;
          end
        end
        S_ADDR: begin
          if (r_cnt == c_addr_last) w_state_next = S_DOUT;
        end
        default: w_state_next = r_state;
      endcase
    end
  end

  always_ff @(posedge mem_clk) begin
    if (rst) begin
      // A frame already in progress at reset is never decoded
      r_state    <= mem_ce ? S_IDLE : S_IGNORE;
      r_cnt      <= 5'd0;
      r_shift    <= 7'd0;
      r_id       <= 15'd0;
      r_dout     <= 1'b0;
      r_oe       <= 1'b0;
      r_valid    <= 1'b0;
      r_cmd      <= 8'd0;
      r_qpi      <= 1'b0;
      r_rst_done <= 1'b0;
      r_armed    <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_valid    <= 1'b0;
      r_rst_done <= 1'b0;
      if (mem_ce) begin
        r_cnt  <= 5'd0;
        r_oe   <= 1'b0;
        r_dout <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_CMD: begin
            r_shift <= r_qpi ? {r_shift[2:0], sio_in} : {r_shift[5:0], sio_in[0]};
            r_cnt   <= w_last ? 5'd0 : r_cnt + 5'd1;
            if (w_last) begin
              r_valid <= 1'b1;
              r_cmd   <= w_cmd_word;
              r_armed <= (w_cmd_word == c_cmd_rsten);
              case (w_cmd_word)
                c_cmd_rst: begin
                  if (r_armed) begin
                    r_qpi      <= 1'b0;
                    r_rst_done <= 1'b1;
                  end
                end
                c_cmd_qpi_en:   r_qpi <= 1'b1;
                // Exit is a no-op when already in SPI mode
                c_cmd_qpi_exit: r_qpi <= 1'b0;
                default:        r_qpi <= r_qpi;
              endcase
            end
          end
          S_ADDR: begin
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == c_addr_last) begin
              r_oe   <= 1'b1;
              r_dout <= MF_ID[7];
              r_id   <= {MF_ID[6:0], KGD};
            end
          end
          S_DOUT: begin
            r_dout <= r_id[14];
            r_id   <= {r_id[13:0], 1'b0};
          end
          default: r_cnt <= r_cnt;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_psram_cmd_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_psram_cmd_responder
// Purpose  : Directed self-checking bench for psram_cmd_responder.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_psram_cmd_responder;

  logic       mem_clk = 1'b0;
  logic       rst;
  logic       mem_ce;
  logic [3:0] sio_in;
  logic [3:0] sio_out;
  logic [3:0] sio_oe;
  logic       cmd_valid;
  logic [7:0] cmd_byte;
  logic       qpi_mode;
  logic       rst_done;
  logic       rsten_armed;

  int n_checks = 0;
  int n_pass   = 0;

  psram_cmd_responder #(.MF_ID(8'h0D), .KGD(8'h5D)) dut (
    .mem_clk     (mem_clk),
    .rst         (rst),
    .mem_ce      (mem_ce),
    .sio_in      (sio_in),
    .sio_out     (sio_out),
    .sio_oe      (sio_oe),
    .cmd_valid   (cmd_valid),
    .cmd_byte    (cmd_byte),
    .qpi_mode    (qpi_mode),
    .rst_done    (rst_done),
    .rsten_armed (rsten_armed)
  );

  always #5 mem_clk = ~mem_clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed === expected) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  // One rising edge with the given CE/SIO; returns 1ns after the edge
  task automatic clk_edge(input logic ce, input logic [3:0] sio);
    @(negedge mem_clk);
    mem_ce = ce;
    sio_in = sio;
    @(posedge mem_clk);
    #1;
  endtask

  task automatic ce_high();
    clk_edge(1'b1, 4'h0);
  endtask

  // Sends a full SPI command; seen_early flags any cmd_valid before the 8th edge
  task automatic spi_cmd(input logic [7:0] b, output logic seen_early);
    seen_early = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      clk_edge(1'b0, {3'b000, b[i]});
      if (i != 0) seen_early |= cmd_valid;
    end
  endtask

  task automatic qpi_cmd(input logic [7:0] b, output logic seen_early);
    clk_edge(1'b0, b[7:4]);
    seen_early = cmd_valid;
    clk_edge(1'b0, b[3:0]);
  endtask

  initial begin
    logic        early;
    logic        seen;
    logic [15:0] id;
    logic        tail_or;
    logic        oe_and;
    logic [7:0]  pat;

    rst = 1'b1; mem_ce = 1'b1; sio_in = 4'h0;
    clk_edge(1'b1, 4'h0);
    clk_edge(1'b1, 4'h0);
    check("rst_sio_out", 32'(sio_out), 32'h0);
    check("rst_sio_oe", 32'(sio_oe), 32'h0);
    check("rst_cmd_valid", 32'(cmd_valid), 32'h0);
    check("rst_cmd_byte", 32'(cmd_byte), 32'h0);
    check("rst_qpi_mode", 32'(qpi_mode), 32'h0);
    check("rst_rst_done", 32'(rst_done), 32'h0);
    check("rst_armed", 32'(rsten_armed), 32'h0);
    rst = 1'b0;
    ce_high();

    // Unarmed RST: accepted as a command, no reset effect
    spi_cmd(8'h99, early);
    check("unarmed99_latency", 32'(early), 32'h0);
    check("unarmed99_valid", 32'(cmd_valid), 32'h1);
    check("unarmed99_byte", 32'(cmd_byte), 32'h99);
    check("unarmed99_rst_done", 32'(rst_done), 32'h0);
    check("unarmed99_qpi", 32'(qpi_mode), 32'h0);
    ce_high();
    check("valid_pulse_width", 32'(cmd_valid), 32'h0);
    check("cmd_byte_hold", 32'(cmd_byte), 32'h99);

    // RSTEN, RST, QPI enable
    spi_cmd(8'h66, early);
    check("rsten_valid", 32'(cmd_valid), 32'h1);
    check("rsten_byte", 32'(cmd_byte), 32'h66);
    check("rsten_armed", 32'(rsten_armed), 32'h1);
    ce_high();
    spi_cmd(8'h99, early);
    check("rst_valid", 32'(cmd_valid), 32'h1);
    check("rst_byte", 32'(cmd_byte), 32'h99);
    check("rst_pulse", 32'(rst_done), 32'h1);
    check("rst_disarm", 32'(rsten_armed), 32'h0);
    ce_high();
    check("rst_pulse_width", 32'(rst_done), 32'h0);
    spi_cmd(8'h35, early);
    check("qpien_byte", 32'(cmd_byte), 32'h35);
    check("qpien_mode", 32'(qpi_mode), 32'h1);
    check("qpien_rst_done", 32'(rst_done), 32'h0);
    ce_high();

    // QPI: arm then clear, then unarmed RST
    qpi_cmd(8'h66, early);
    check("q66_latency", 32'(early), 32'h0);
    check("q66_valid", 32'(cmd_valid), 32'h1);
    check("q66_armed", 32'(rsten_armed), 32'h1);
    ce_high();
    qpi_cmd(8'h35, early);
    check("q35_disarm", 32'(rsten_armed), 32'h0);
    ce_high();
    qpi_cmd(8'h99, early);
    check("q99_byte", 32'(cmd_byte), 32'h99);
    check("q99_no_rst_done", 32'(rst_done), 32'h0);
    check("q99_qpi_kept", 32'(qpi_mode), 32'h1);
    ce_high();

    // QPI exit, then SPI enable
    qpi_cmd(8'hF5, early);
    check("qf5_byte", 32'(cmd_byte), 32'hF5);
    check("qf5_mode", 32'(qpi_mode), 32'h0);
    ce_high();
    spi_cmd(8'h35, early);
    check("spi35_again", 32'(qpi_mode), 32'h1);
    ce_high();

    // Armed RST in QPI drops back to SPI
    qpi_cmd(8'h66, early);
    ce_high();
    qpi_cmd(8'h99, early);
    check("q_rst_pulse", 32'(rst_done), 32'h1);
    check("q_rst_mode", 32'(qpi_mode), 32'h0);
    ce_high();

    // Abort after 5 bits of 0x66
    pat = 8'h66;
    seen = 1'b0;
    for (int i = 7; i >= 3; i--) begin
      clk_edge(1'b0, {3'b000, pat[i]});
      seen |= cmd_valid;
    end
    ce_high();
    seen |= cmd_valid;
    check("abort_no_valid", 32'(seen), 32'h0);
    check("abort_armed", 32'(rsten_armed), 32'h0);
    check("abort_byte_hold", 32'(cmd_byte), 32'h99);
    spi_cmd(8'h66, early);
    check("post_abort_byte", 32'(cmd_byte), 32'h66);
    check("post_abort_armed", 32'(rsten_armed), 32'h1);

    // Trailing bits of 0x99 in the same frame are ignored
    pat = 8'h99;
    seen = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      clk_edge(1'b0, {3'b000, pat[i]});
      if (i != 7) seen |= cmd_valid | rst_done;
    end
    check("extra_bits_ignored", 32'(seen), 32'h0);
    check("extra_bits_armed", 32'(rsten_armed), 32'h1);
    ce_high();

    // Read-ID
    spi_cmd(8'h9F, early);
    check("rdid_byte", 32'(cmd_byte), 32'h9F);
    check("rdid_disarm", 32'(rsten_armed), 32'h0);
    for (int a = 1; a <= 24; a++) begin
      clk_edge(1'b0, {3'b000, 1'(a)});
      if (a == 1)  check("rdid_valid_pulse", 32'(cmd_valid), 32'h0);
      if (a == 23) check("rdid_oe_edge31", 32'(sio_oe), 32'h0);
      if (a == 24) check("rdid_oe_edge32", 32'(sio_oe), 32'h2);
    end
    id[15] = sio_out[1];
    for (int k = 1; k <= 15; k++) begin
      clk_edge(1'b0, 4'h0);
      id[15-k] = sio_out[1];
    end
    check("rdid_bits", 32'(id), 32'h0D5D);
    tail_or = 1'b0;
    oe_and  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      clk_edge(1'b0, 4'hF);
      tail_or |= sio_out[1];
      oe_and  &= sio_oe[1];
    end
    check("rdid_tail_zero", 32'(tail_or), 32'h0);
    check("rdid_oe_held", 32'(oe_and), 32'h1);
    ce_high();
    check("rdid_oe_drop", 32'(sio_oe), 32'h0);

    // Reset mid-frame
    spi_cmd(8'h66, early);
    ce_high();
    pat = 8'h66;
    for (int i = 7; i >= 5; i--) clk_edge(1'b0, {3'b000, pat[i]});
    rst = 1'b1;
    clk_edge(1'b0, {3'b000, pat[4]});
    rst = 1'b0;
    check("midrst_byte", 32'(cmd_byte), 32'h0);
    check("midrst_armed", 32'(rsten_armed), 32'h0);
    check("midrst_valid", 32'(cmd_valid), 32'h0);
    seen = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      clk_edge(1'b0, {3'b000, pat[i]});
      seen |= cmd_valid;
    end
    check("midrst_frame_ignored", 32'(seen), 32'h0);
    ce_high();
    spi_cmd(8'h66, early);
    check("post_rst_valid", 32'(cmd_valid), 32'h1);
    check("post_rst_armed", 32'(rsten_armed), 32'h1);
    ce_high();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
